// File: rtl/muldiv_unit.sv
// Iterative 32-bit unsigned multiply/divide unit (shift-add multiply, restoring divide).
// Optional macro MULDIV_DIV0_BYPASS_EN: divide-by-zero completes in one cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic [WIDTH-1:0] rs2_val,
  input  logic [AW-1:0]    rd_addr,
  output logic             busy,
  output logic             wb_we,
  output logic [AW-1:0]    wb_addr,
  output logic [WIDTH-1:0] wb_data
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_q;
  logic [AW-1:0]      rd_q;
  logic [WIDTH-1:0]   a_q;      // multiplier (shifts right) / dividend->quotient (shifts left)
  logic [WIDTH-1:0]   b_q;      // multiplicand / divisor
  logic [2*WIDTH-1:0] acc;      // product; upper half doubles as partial remainder

  logic [2*WIDTH-1:0] acc_n;
  logic [WIDTH-1:0]   a_n;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   result;

  assign busy = (state != IDLE);

  always_comb begin
    acc_n   = acc;
    a_n     = a_q;
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (a_q[0] ? b_q : {WIDTH{1'b0}})};
    trial   = {acc[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    if (!op_q[1]) begin
      acc_n = {add_sum, acc[WIDTH-1:1]};
      a_n   = {1'b0, a_q[WIDTH-1:1]};
    end else if (trial >= {1'b0, b_q}) begin
      // partial remainder < divisor keeps the difference within WIDTH bits
      acc_n = {trial[WIDTH-1:0] - b_q, acc[WIDTH-1:0]};
      a_n   = {a_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_n = {trial[WIDTH-1:0], acc[WIDTH-1:0]};
      a_n   = {a_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    case (op_q)
      2'b00:   result = acc_n[WIDTH-1:0];
      2'b01:   result = acc_n[2*WIDTH-1:WIDTH];
      2'b10:   result = a_n;
      default: result = acc_n[2*WIDTH-1:WIDTH];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          wb_we <= 1'b0;
          if (start) begin
            op_q <= op;
            a_q  <= rs1_val;
            b_q  <= rs2_val;
            rd_q <= rd_addr;
            acc  <= '0;
            cnt  <= '0;
`ifdef MULDIV_DIV0_BYPASS_EN
            if (op[1] && (rs2_val == '0)) begin
              state   <= DONE;
              wb_we   <= (rd_addr != '0);
              wb_addr <= rd_addr;
              wb_data <= op[0] ? rs1_val : {WIDTH{1'b1}};
            end else
`endif
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_n;
          a_q <= a_n;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) begin
            state   <= DONE;
            wb_we   <= (rd_q != '0);
            wb_addr <= rd_q;
            wb_data <= result;
          end
        end
        DONE: begin
          wb_we <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
